// File: rtl/sink_pkg.sv
// Shared types and sequence helpers for the 4-bit sink checker stage.
// Holds the Mode and state encodings plus the next-value and validity rules.
package sink_pkg;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'b00,
    MODE_WALK = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_HUNT   = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  // Feedback taps x[3]^x[2]; this polynomial never leaves or enters 0000.
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic [3:0] next_value(input mode_e mode, input logic [3:0] x);
    logic [3:0] n;
    case (mode)
      MODE_CNT:  n = x + 4'd1;
      MODE_WALK: n = {x[2:0], x[3]};
      MODE_LFSR: n = {x[2:0], ^(x & LFSR_TAPS)};
      default:   n = x;
    endcase
    return n;
  endfunction

  function automatic logic is_valid(input mode_e mode, input logic [3:0] x);
    logic v;
    case (mode)
      MODE_CNT:  v = 1'b1;
      MODE_WALK: v = (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
      MODE_LFSR: v = (x != 4'd0);
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sink_if.sv
// Data/status bundle between the upstream register stage and the sink checker.
// The master side drives words and controls; the slave (sink) reports status.
interface sink_if #(
  parameter int CNT_W = 16
);

  logic [3:0]       Din;
  logic [1:0]       Mode;
  logic             Clear;
  logic             Locked;
  logic             Err;
  logic [CNT_W-1:0] ErrCount;

  modport master (
    output Din, Mode, Clear,
    input  Locked, Err, ErrCount
  );

  modport slave (
    input  Din, Mode, Clear,
    output Locked, Err, ErrCount
  );

endinterface

// File: rtl/sink_next_value.sv
// Combinational next-word prediction and word validity for the selected Mode.
// One instance serves both the reseeding (HUNT) and free-running (LOCKED) paths.
module sink_next_value
  import sink_pkg::*;
(
  input  mode_e      mode,
  input  logic [3:0] x,
  output logic [3:0] nxt,
  output logic       valid
);

  assign nxt   = next_value(mode, x);
  assign valid = is_valid(mode, x);

endmodule

// File: rtl/sink_module.sv
// Sink checker: locks onto a counter, walking-one or LFSR sequence and counts
// mismatching words once locked, with registered status outputs.
module sink_module
  import sink_pkg::*;
#(
  parameter int LOCK_LEN = 4,
  parameter int MISS_LEN = 3,
  parameter int CNT_W    = 16
) (
  input  logic    CLK,
  input  logic    RSTn,
  sink_if.slave   bus
);

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_LEN);
  localparam logic [3:0]       MISS_N  = 4'(MISS_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       in_r;
  logic [3:0]       exp_r;
  logic             exp_ok_r;
  state_e           state_r;
  mode_e            mode_prev_r;
  logic [3:0]       match_r;
  logic [3:0]       miss_r;
  logic             locked_r;
  logic             err_r;
  logic [CNT_W-1:0] err_cnt_r;

  mode_e      mode_s;
  logic       mode_chg_s;
  logic [3:0] nv_x_s;
  logic [3:0] nv_s;
  logic       nv_valid_s;
  logic       hit_s;
  logic       mismatch_s;
  logic       count_s;
  logic [3:0] match_inc_s;
  logic [3:0] miss_inc_s;

  assign mode_s     = mode_e'(bus.Mode);
  assign mode_chg_s = (mode_s != mode_prev_r);

  // HUNT predicts from the captured word, LOCKED from its own previous prediction.
  assign nv_x_s = (state_r == ST_LOCKED) ? exp_r : in_r;

  sink_next_value u_next (
    .mode  (mode_s),
    .x     (nv_x_s),
    .nxt   (nv_s),
    .valid (nv_valid_s)
  );

  assign hit_s       = exp_ok_r && (in_r == exp_r) && nv_valid_s;
  assign mismatch_s  = (in_r != exp_r);
  assign count_s     = !mode_chg_s && (state_r == ST_LOCKED) && mismatch_s;
  assign match_inc_s = match_r + 4'd1;
  assign miss_inc_s  = miss_r + 4'd1;

  // Lock state machine, prediction register and error counter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      in_r        <= 4'd0;
      exp_r       <= 4'd0;
      exp_ok_r    <= 1'b0;
      state_r     <= ST_HUNT;
      mode_prev_r <= MODE_CNT;
      match_r     <= 4'd0;
      miss_r      <= 4'd0;
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      err_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      in_r        <= bus.Din;
      mode_prev_r <= mode_s;
      err_r       <= 1'b0;

      if (bus.Clear) begin
        err_cnt_r <= {CNT_W{1'b0}};
      end else if (count_s && (err_cnt_r != CNT_MAX)) begin
        err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_r <= err_cnt_r;
      end

      if (mode_chg_s) begin
        state_r  <= (mode_s == MODE_OFF) ? ST_OFF : ST_HUNT;
        match_r  <= 4'd0;
        miss_r   <= 4'd0;
        exp_ok_r <= 1'b0;
        locked_r <= 1'b0;
      end else begin
        case (state_r)
          ST_OFF: begin
            locked_r <= 1'b0;
          end
          ST_HUNT: begin
            exp_r    <= nv_s;
            exp_ok_r <= 1'b1;
            if (hit_s) begin
              if (match_inc_s == LOCK_N) begin
                state_r  <= ST_LOCKED;
                locked_r <= 1'b1;
                match_r  <= 4'd0;
              end else begin
                match_r <= match_inc_s;
              end
            end else begin
              match_r <= 4'd0;
            end
          end
          ST_LOCKED: begin
            exp_r <= nv_s;
            err_r <= mismatch_s;
            if (mismatch_s) begin
              if (miss_inc_s == MISS_N) begin
                state_r  <= ST_HUNT;
                locked_r <= 1'b0;
                miss_r   <= 4'd0;
              end else begin
                miss_r <= miss_inc_s;
              end
            end else begin
              miss_r <= 4'd0;
            end
          end
          default: begin
            state_r  <= ST_HUNT;
            match_r  <= 4'd0;
            miss_r   <= 4'd0;
            exp_ok_r <= 1'b0;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Locked   = locked_r;
  assign bus.Err      = err_r;
  assign bus.ErrCount = err_cnt_r;

endmodule

// File: doc/sink_module.md
# sink_module

Downstream checker stage for the 4-bit registered data path: consumes the 4-bit word delivered each cycle by the preceding register stage, locks onto a known test sequence (counter, walking-one, or 4-bit LFSR), and reports lock status, per-cycle mismatch pulses and a saturating error count. It closes the source → register → sink chain used for timing experiments, so a timing failure in the path shows up as counted errors.

## Interface
- LOCK_LEN, 4: consecutive correct predictions in HUNT needed to enter LOCKED (1..15)
- MISS_LEN, 3: consecutive mismatches in LOCKED that drop lock (1..15)
- CNT_W, 16: width of ErrCount
- CLK  in  1  clock, all logic rising-edge
- RSTn  in  1  reset, asynchronous, active-low
- Din  in  4  data word from the upstream register stage, one word per cycle
- Mode  in  2  00 counter, 01 walking-one, 10 LFSR, 11 off
- Clear  in  1  synchronous clear of ErrCount, single-cycle or level
- Locked  out  1  registered, high while in LOCKED
- Err  out  1  registered, one-cycle pulse per mismatching word while LOCKED
- ErrCount  out  CNT_W  registered, saturating mismatch count

## Operation
- Input register: Din captured into rIn every edge; all checking uses rIn, never raw Din.
- Next-value function f(x): counter x+1 mod 16; walking-one rotate left (0001→0010→0100→1000→0001); LFSR {x[2:0], x[3]^x[2]}, period 15, 0000 never valid.
- Valid word: counter any; walking-one exactly one bit set; LFSR nonzero. Mode 11 none.
- States: OFF, HUNT, LOCKED.
  - OFF: entered when Mode=11; Locked=0, Err=0, no counting.
  - HUNT: each cycle, if rIn equals rExp and rIn valid, match counter +1, else match counter cleared. rExp <= f(rIn) every cycle (reseeded from data). Match counter reaching LOCK_LEN → LOCKED.
  - LOCKED: rExp <= f(rExp) (free-running, not reseeded, so an isolated error does not shift alignment). rIn≠rExp → Err pulse, ErrCount +1 (saturate at all-ones), miss counter +1; match → miss counter 0. Miss counter reaching MISS_LEN → HUNT, Locked falls.
- Mode change (Mode differs from last-cycle Mode) → HUNT from any state (or OFF if new Mode=11), match/miss counters cleared, rExp invalidated; ErrCount kept.
- Clear: ErrCount <= 0; Clear and a mismatch on the same edge → Clear wins, ErrCount=0; Err pulse still issued.
- Invalid word in HUNT never counts as a match, even if equal to rExp.

## Timing
- Reset: rIn=0, rExp=0, state=HUNT, counters 0, Locked=0, Err=0, ErrCount=0. Reset mid-operation returns to these immediately, independent of CLK.
- Latency: Din present before edge k → captured at k → compared at k+1 → Err high in cycle after edge k+1 (2 clocks Din→Err).
- Lock: with clean sequence from first word at edge k, Locked rises after edge k+LOCK_LEN+1.
- Lock loss: Locked falls on the edge that registers the MISS_LEN-th consecutive mismatch; that mismatch still pulses Err and counts.
- No handshake: one word consumed per cycle, no backpressure.

## Structure
- Package sink_pkg: Mode encodings, state encoding (OFF/HUNT/LOCKED), LFSR tap constant, next-value function and validity function.
- One sub-module sink_next_value: combinational f(x) and valid(x) per Mode, shared by HUNT and LOCKED paths.

## Test plan
- Counter 0,1,2,… from reset, Mode=00 → Locked rises 5 edges after first capture, Err never asserts, ErrCount=0.
- Locked on counter, one word corrupted (7 replaced by 0xF) → single Err pulse 2 cycles later, ErrCount=1, Locked stays 1, next word 8 checks clean.
- LFSR seed 0001, Mode=10, locked; then stuck Din=0x0 for 3 cycles → 3 Err pulses, ErrCount=3, Locked falls on third; relock after sequence resumes.
- Walking-one with Din=0011 inserted in HUNT → match counter clears, lock delayed by that word plus LOCK_LEN.
- ErrCount at all-ones (CNT_W=4, 15) plus further errors → stays 15; Clear together with mismatch → 0, Err still pulses.
- Assert RSTn low mid-lock → Locked, Err, ErrCount 0 immediately; Mode=11 → no Err regardless of Din.
